// File: rtl/cdb_arbiter_pkg.sv
// Common-data-bus field layout, functional-unit tags and request-slot indices
// shared by the arbiter, the functional units and the bench.
package cdb_arbiter_pkg;

  localparam int NUM_CDBBITS  = 39;
  localparam int CDB_ON_FIELD = 38;
  localparam int CDB_FU_MSB   = 37;
  localparam int CDB_FU_LSB   = 35;
  localparam int CDB_RS_MSB   = 34;
  localparam int CDB_RS_LSB   = 32;
  localparam int PAYLOAD_W    = NUM_CDBBITS - 1;

  typedef logic [2:0] fu_tag_t;

  // Tag 0 is left unused so an all-zero idle bus never aliases a real unit.
  localparam fu_tag_t FU_ALU_TAG  = 3'd1;
  localparam fu_tag_t FU_JUMP_TAG = 3'd2;
  localparam fu_tag_t FU_LS_TAG   = 3'd3;
  localparam fu_tag_t FU_MUL_TAG  = 3'd4;
  localparam fu_tag_t FU_DIV_TAG  = 3'd5;

  localparam int ALU_IDX  = 0;
  localparam int JUMP_IDX = 1;
  localparam int LS_IDX   = 2;
  localparam int MUL_IDX  = 3;
  localparam int DIV_IDX  = 4;

  typedef struct packed {
    fu_tag_t     fu;
    logic [2:0]  rs;
    logic [31:0] value;
  } cdb_payload_t;

  function automatic cdb_payload_t make_payload(input fu_tag_t fu, input logic [2:0] rs,
                                                input logic [31:0] value);
    cdb_payload_t p;
    p.fu    = fu;
    p.rs    = rs;
    p.value = value;
    return p;
  endfunction

endpackage

// File: rtl/cdb_rr_pick.sv
// Combinational rotate-priority picker: first eligible bit at or after rr_ptr,
// wrapping past NUM_FU-1 back to 0.
module cdb_rr_pick #(
  parameter  int NUM_FU = 5,
  localparam int IDX_W  = $clog2(NUM_FU)
) (
  input  logic [NUM_FU-1:0] eligible,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic [NUM_FU-1:0] sel,
  output logic [IDX_W-1:0]  sel_idx
);

  int               j;
  logic [IDX_W-1:0] jj;
  logic             found;

  always_comb begin
    sel     = '0;
    sel_idx = '0;
    found   = 1'b0;
    j       = 0;
    jj      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_FU) j = j - NUM_FU;
      jj = IDX_W'(j);
      if (!found && eligible[jj]) begin
        found   = 1'b1;
        sel[jj] = 1'b1;
        sel_idx = jj;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: grants one requesting unit per cycle and
// broadcasts {on, payload} on a registered bus, with per-unit starvation watch.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU   = 5,
  parameter int MAX_WAIT = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_FU-1:0]           req,
  input  logic [NUM_FU*PAYLOAD_W-1:0] payload_in,
  output logic [NUM_CDBBITS-1:0]      cdb,
  output logic [NUM_FU-1:0]           grant,
  output logic                        starve_err
);

  localparam int         IDX_W      = $clog2(NUM_FU);
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  // Request/grant protocol: a unit holds req with a stable payload until it sees
  // its own tag on cdb with the on bit set; that cycle is its single broadcast.
  // The unit granted last cycle is masked out, so it may drop req late.
  logic [NUM_CDBBITS-1:0] cdb_q, cdb_d;
  logic [NUM_FU-1:0]      grant_q, grant_d;
  logic                   starve_q, starve_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [7:0]             wait_q [NUM_FU];
  logic [7:0]             wait_d [NUM_FU];

  logic [NUM_FU-1:0]      eligible;
  logic [NUM_FU-1:0]      sel;
  logic [IDX_W-1:0]       sel_idx;
  logic [PAYLOAD_W-1:0]   sel_payload;

  assign eligible = req & ~grant_q;

  cdb_rr_pick #(.NUM_FU(NUM_FU)) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .sel      (sel),
    .sel_idx  (sel_idx)
  );

  always_comb begin
    // One-hot AND-OR mux keeps payload bits of unselected units off the bus.
    sel_payload = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (sel[i]) sel_payload = sel_payload | payload_in[i*PAYLOAD_W +: PAYLOAD_W];
    end

    cdb_d    = (|eligible) ? {1'b1, sel_payload} : '0;
    grant_d  = sel;
    rr_ptr_d = rr_ptr_q;
    if (|eligible) begin
      rr_ptr_d = (sel_idx == IDX_W'(NUM_FU - 1)) ? '0 : sel_idx + IDX_W'(1);
    end

    starve_d = starve_q;
    for (int i = 0; i < NUM_FU; i++) begin
      wait_d[i] = '0;
      if (req[i] && !sel[i]) begin
        if (wait_q[i] >= WAIT_LIMIT - 8'd1) begin
          starve_d  = 1'b1;
          wait_d[i] = WAIT_LIMIT;
        end else begin
          wait_d[i] = wait_q[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_q    <= '0;
      grant_q  <= '0;
      starve_q <= 1'b0;
      rr_ptr_q <= '0;
      for (int i = 0; i < NUM_FU; i++) wait_q[i] <= '0;
    end else begin
      cdb_q    <= cdb_d;
      grant_q  <= grant_d;
      starve_q <= starve_d;
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < NUM_FU; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign cdb        = cdb_q;
  assign grant      = grant_q;
  assign starve_err = starve_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single grant, round-robin order,
// lone requester cadence, payload capture and starvation flagging.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = 5;

  logic                   clk;
  logic                   rst;
  logic [N-1:0]           req;
  logic [N-1:0]           req_s;
  logic [N*PAYLOAD_W-1:0] payload_in;
  logic [NUM_CDBBITS-1:0] cdb, cdb_s;
  logic [N-1:0]           grant, grant_s;
  logic                   starve_err, starve_s;
  cdb_payload_t           pl [N];

  int errors = 0;
  int checks = 0;

  always_comb begin
    payload_in = '0;
    for (int i = 0; i < N; i++) payload_in[i*PAYLOAD_W +: PAYLOAD_W] = pl[i];
  end

  cdb_arbiter #(.NUM_FU(N), .MAX_WAIT(16)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .payload_in (payload_in),
    .cdb        (cdb),
    .grant      (grant),
    .starve_err (starve_err)
  );

  // Short starvation limit so round-robin waits under all-request load exceed it.
  cdb_arbiter #(.NUM_FU(N), .MAX_WAIT(4)) u_dut_s (
    .clk        (clk),
    .rst        (rst),
    .req        (req_s),
    .payload_in (payload_in),
    .cdb        (cdb_s),
    .grant      (grant_s),
    .starve_err (starve_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    cdb_payload_t p;
    rst   = 1'b1;
    req   = '0;
    req_s = '0;
    for (int i = 0; i < N; i++) pl[i] = '0;

    // Reset and idle
    tick(); tick();
    chk("rst_cdb", 64'(cdb), 64'(0));
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_starve", 64'(starve_err), 64'(0));
    rst = 1'b0;
    tick();
    chk("idle_cdb", 64'(cdb), 64'(0));

    // Single MUL request
    pl[MUL_IDX] = make_payload(FU_MUL_TAG, 3'b100, 32'h0000_0042);
    req = 5'b01000;
    tick();
    p = make_payload(FU_MUL_TAG, 3'b100, 32'h0000_0042);
    chk("mul_cdb", 64'(cdb), 64'({1'b1, p}));
    chk("mul_grant", 64'(grant), 64'(5'b01000));
    chk("mul_fu_field", 64'(cdb[CDB_FU_MSB:CDB_FU_LSB]), 64'(FU_MUL_TAG));
    req = '0;
    tick();
    chk("mul_after_cdb", 64'(cdb), 64'(0));
    chk("mul_after_grant", 64'(grant), 64'(0));

    // Reset during a broadcast, with req still high at the reset edge
    req = 5'b01000;
    tick();
    chk("pre_rst_on", 64'(cdb[CDB_ON_FIELD]), 64'(1));
    rst = 1'b1;
    tick();
    chk("mid_rst_cdb", 64'(cdb), 64'(0));
    chk("mid_rst_grant", 64'(grant), 64'(0));
    rst = 1'b0;
    req = '0;

    // All five request from rr_ptr=0: units 0,1,2,3,4,0
    for (int i = 0; i < N; i++) pl[i] = make_payload(fu_tag_t'(i + 1), 3'b001, 32'h1000 + i);
    req = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rr_grant_%0d", k), 64'(grant), 64'(5'b00001 << (k % 5)));
      chk($sformatf("rr_cdb_%0d", k), 64'(cdb), 64'({1'b1, pl[k % 5]}));
    end
    req = '0;
    tick();
    chk("rr_end_cdb", 64'(cdb), 64'(0));

    // Lone requester unit 3: every other cycle
    req = 5'b01000;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("lone_on_%0d", k), 64'(cdb[CDB_ON_FIELD]), 64'((k % 2) == 0));
      chk($sformatf("lone_grant_%0d", k), 64'(grant), 64'((k % 2) == 0 ? 5'b01000 : 5'b00000));
    end
    req = '0;

    // Payload captured only at the grant edge
    pl[JUMP_IDX] = make_payload(FU_JUMP_TAG, 3'b010, 32'hAAAA_0001);
    req = 5'b00010;
    tick();
    p = make_payload(FU_JUMP_TAG, 3'b010, 32'hAAAA_0001);
    chk("hold_cdb_a", 64'(cdb), 64'({1'b1, p}));
    pl[JUMP_IDX] = make_payload(FU_JUMP_TAG, 3'b010, 32'hBBBB_0002);
    #2;
    chk("hold_cdb_after_change", 64'(cdb), 64'({1'b1, p}));
    tick();
    chk("hold_masked_cdb", 64'(cdb), 64'(0));
    tick();
    p = make_payload(FU_JUMP_TAG, 3'b010, 32'hBBBB_0002);
    chk("hold_cdb_b", 64'(cdb), 64'({1'b1, p}));
    req = '0;
    tick();

    // Starvation on the MAX_WAIT=4 instance: unit 4 waits 4 edges
    req_s = 5'b11111;
    tick(); tick(); tick();
    chk("starve_edge3", 64'(starve_s), 64'(0));
    tick();
    chk("starve_edge4", 64'(starve_s), 64'(1));
    chk("starve_grant4", 64'(grant_s), 64'(5'b01000));
    chk("main_no_starve", 64'(starve_err), 64'(0));
    req_s = '0;
    tick(); tick(); tick();
    chk("starve_sticky", 64'(starve_s), 64'(1));
    rst = 1'b1;
    tick();
    chk("starve_cleared", 64'(starve_s), 64'(0));
    rst = 1'b0;

    // 100 cycles of full load on MAX_WAIT=16: strict rotation, no starvation
    req = 5'b11111;
    for (int k = 0; k < 100; k++) begin
      tick();
      chk($sformatf("load_grant_%0d", k), 64'(grant), 64'(5'b00001 << (k % 5)));
    end
    chk("load_no_starve", 64'(starve_err), 64'(0));
    req = '0;
    tick();
    chk("final_idle_cdb", 64'(cdb), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Receiving end of the common-data-bus request protocol that every functional unit (ALU, jump, load/store, multiply, divide) drives.
- Collects each unit's `cdb_request` and `cdb_out` payload, grants at most one unit per cycle by round-robin, and broadcasts `{on, payload}` on the registered `cdb` bus.
- All reservation stations, the register status table and the requesting units sample `cdb`.
- A unit detects its own grant by seeing the on bit set with its FU tag in the FU field.

Parameters:
- NUM_FU, 5, number of requesting functional units; any value 2..8, power of two not required.
- MAX_WAIT, 16, cycles a request may remain pending ungranted before starvation is flagged; legal range 2..255.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- req  in  NUM_FU  per-unit CDB request; bit i = unit i's `cdb_request`.
- payload_in  in  NUM_FU*(`NUM_CDBBITS-1)  flattened per-unit `cdb_out`; slice i = bits [(i+1)*(`NUM_CDBBITS-1)-1 : i*(`NUM_CDBBITS-1)]; slice format {FU tag, RS one-hot[2:0], value[31:0]}.
- cdb  out  `NUM_CDBBITS  broadcast bus; MSB (`CDB_ON_FIELD) is the on bit, remaining bits are the granted payload.
- grant  out  NUM_FU  one-hot copy of the unit currently on `cdb`; all zero when the on bit is 0.
- starve_err  out  1  sticky flag: some request waited MAX_WAIT cycles.

Behaviour:
- Reset (sync, active-high, priority over everything): cdb=0, grant=0, starve_err=0, rr_ptr=0, all wait counters=0. A broadcast in flight is dropped; cdb reads 0 on the cycle after the reset edge.
- Eligibility: eligible = req & ~grant (registered grant). A unit granted in cycle t cannot be granted in cycle t+1. This covers units that clear their request on the negedge after seeing their tag.
- Selection: first set bit of eligible scanning rr_ptr, rr_ptr+1, ..., NUM_FU-1, 0, ... cyclically.
- On a posedge with eligible != 0 (selected index s):
  - cdb <= {1'b1, payload slice s};
  - grant <= one-hot(s);
  - rr_ptr <= (s == NUM_FU-1) ? 0 : s+1.
- On a posedge with eligible == 0: cdb <= 0 (all fields zero, not only the on bit), grant <= 0, rr_ptr unchanged.
- Latency: a request present before posedge k appears on cdb from k to k+1, held exactly one cycle. Payload is sampled only at the grant edge; later payload changes are ignored.
- Throughput: one broadcast per cycle when two or more units request. A single continuously requesting unit gets every other cycle.
- Wait counters, one per unit, 8-bit, saturating at MAX_WAIT:
  - counter increments when req[i]=1 and unit i is not selected this edge;
  - counter clears when req[i]=0 or unit i is selected;
  - on any edge where a counter would reach MAX_WAIT, starve_err <= 1 and stays set until rst.
- Simultaneous requests from all units are served in cyclic order from rr_ptr. No unit waits more than NUM_FU cycles while requesting continuously.
- Request dropped before being granted: the unit is simply not selected and its counter clears. No error.
- X/unused payload bits of non-selected units never reach cdb.

Decomposition:
- Shared define/package (define.vh):
  - `NUM_CDBBITS, `CDB_ON_FIELD, `CDB_FU_FIELD, `CDB_RS_FIELD;
  - FU tag constants (`FU_MUL_TAG etc.);
  - unit-index constants mapping each FU to its req/payload slot (ALU=0, JUMP=1, LS=2, MUL=3, DIV=4).
- One sub-module, cdb_rr_pick: purely combinational NUM_FU-wide rotate-priority picker. Inputs: eligible, rr_ptr. Outputs: one-hot select and its index. The parent holds all registers.

Test Plan (NUM_FU=5, MAX_WAIT=16):
1. Reset then idle: rst=1 for 2 edges, req=0 -> cdb=0, grant=0, starve_err=0. Assert rst mid-broadcast -> cdb=0 on the next cycle.
2. Single request, MUL slot 3: payload {MUL tag, 3'b100, 32'h0000_0042}, req=5'b01000 for one cycle -> next cycle cdb={1, MUL tag, 3'b100, 32'h42}, grant=5'b01000; following cycle cdb=0.
3. All five request continuously from rr_ptr=0 -> grants over 5 cycles are units 0,1,2,3,4, then 0 again. No unit is granted on two consecutive cycles.
4. Unit 3 holds req high alone for 6 cycles -> grant pattern 3,-,3,-,3,- with cdb on bit 1,0,1,0,1,0.
5. Payload change after grant: unit 1 granted with value 32'hAAAA_0001, then slice 1 changes to 32'hBBBB_0002 during broadcast -> cdb value stays 32'hAAAA_0001.
6. Starvation: force a test harness in which unit 4's req stays high while the selection is stubbed to skip it for 16 edges -> starve_err=1 on the 16th edge and remains 1 until rst. With normal round-robin and all requests high for 100 cycles -> starve_err stays 0.
